// File: rtl/ad9122_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : ad9122_pkg                                                     |
// | Purpose : Shared types and constants for the AD9122 serial-port master.  |
// |           Holds the frame FSM state encoding and the frame geometry.     |
// | Ports   : none (package)                                                 |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package ad9122_pkg;

  localparam int FRAME_BITS = 16;  // instruction byte + data byte
  localparam int INSTR_W    = 8;
  localparam int DATA_W     = 8;
  localparam int RW_BIT     = 7;   // instruction bit carrying read(1)/write(0)

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ad9122_sclk_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : ad9122_sclk_gen                                                |
// | Purpose : SCLK half-period divider. While enabled it counts CLK_DIV      |
// |           clocks per half period, starting with a low half, and flags    |
// |           the last clock of each half.                                   |
// | Ports   : clk, rstn     - clock, async active-low reset                  |
// |           en            - run the divider (held in reset when low)       |
// |           rise_stb      - last clock of a low half (SCLK rises next edge)|
// |           fall_stb      - last clock of a high half (SCLK falls next)    |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module ad9122_sclk_gen
  import ad9122_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int                 c_cnt_w = $clog2(CLK_DIV);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(CLK_DIV - 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic               r_high;   // which half of the SCLK period we are in
  logic               w_wrap;

  assign w_wrap   = en && (r_cnt == c_last);
  assign rise_stb = w_wrap && !r_high;
  assign fall_stb = w_wrap &&  r_high;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt  <= '0;
      r_high <= 1'b0;
    end else if (!en) begin
      // Restart aligned so the first enabled cycle begins a low half.
      r_cnt  <= '0;
      r_high <= 1'b0;
    end else if (w_wrap) begin
      r_cnt  <= '0;
      r_high <= !r_high;
    end else begin
      r_cnt  <= r_cnt + c_cnt_w'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/ad9122_spi_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : ad9122_spi_master                                              |
// | Purpose : Serial-port master for the AD9122 control interface. Takes a   |
// |           one-cycle write/read request and shifts out one 16-bit frame   |
// |           {rw, addr[6:0], data}, MSB first, capturing the returned byte  |
// |           on reads. Frame: SETUP, 16 SCLK bits, HOLD, GAP, then IDLE.    |
// | Macro   : AD9122_SPI_3WIRE_EN - 3-wire SDIO; spi_sdo_oe released during  |
// |           the data phase of read frames. Undefined: 4-wire, oe fixed 1.  |
// | Ports   : clk, rstn            - clock, async active-low reset           |
// |           ad_rw_addr, w_ad_data - instruction (bit 7 replaced), wdata    |
// |           write_req, read_req  - one-cycle requests (both high = read)   |
// |           r_w_end, busy        - frame-done pulse, busy flag             |
// |           r_ad_data, rd_valid  - last byte read, read-done pulse         |
// |           spi_csn/sclk/sdo/sdo_oe/sdi - serial port pins                 |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module ad9122_spi_master
  import ad9122_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [INSTR_W-1:0] ad_rw_addr,
  input  logic [DATA_W-1:0] w_ad_data,
  input  logic              write_req,
  input  logic              read_req,
  output logic              r_w_end,
  output logic              busy,
  output logic [DATA_W-1:0] r_ad_data,
  output logic              rd_valid,
  output logic              spi_csn,
  output logic              spi_sclk,
  output logic              spi_sdo,
  output logic              spi_sdo_oe,
  input  logic              spi_sdi
);

  localparam int                 c_cnt_w    = $clog2(CLK_DIV);
  localparam logic [c_cnt_w-1:0] c_last     = c_cnt_w'(CLK_DIV - 1);
  localparam logic [c_cnt_w-1:0] c_end      = c_cnt_w'(CLK_DIV - 2);
  localparam logic [4:0]         c_bit_last = 5'(FRAME_BITS - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [c_cnt_w-1:0]      r_cnt;      // phase timer for SETUP/HOLD/GAP
  logic [4:0]              r_bit;      // bit index within SHIFT, 0..15
  logic [FRAME_BITS-1:0]   r_tx;
  logic [DATA_W-1:0]       r_rx;       // only the last DATA_W samples matter
  logic                    r_rd;
  logic                    w_accept;
  logic                    w_phase_last;
  logic                    w_end_nxt;
  logic                    w_sel_nxt;
  logic                    w_rise;
  logic                    w_fall;
  logic                    w_unused;

  // The incoming R/W bit is overwritten by the request type.
  assign w_unused     = ad_rw_addr[RW_BIT];
  assign w_phase_last = (r_cnt == c_last);

  ad9122_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk      (clk),
    .rstn     (rstn),
    .en       (r_state == ST_SHIFT),
    .rise_stb (w_rise),
    .fall_stb (w_fall)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (write_req || read_req) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: if (w_phase_last) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_fall && (r_bit == c_bit_last)) w_state_nxt = ST_HOLD;
      ST_HOLD:  if (w_phase_last) w_state_nxt = ST_GAP;
      ST_GAP:   if (w_phase_last) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    // Registered one cycle early so r_w_end lands in the last GAP cycle.
    w_end_nxt = (r_state == ST_GAP) && (r_cnt == c_end);
    w_sel_nxt = (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_SHIFT) ||
                (w_state_nxt == ST_HOLD);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_rd       <= 1'b0;
      r_w_end    <= 1'b0;
      busy       <= 1'b0;
      r_ad_data  <= '0;
      rd_valid   <= 1'b0;
      spi_csn    <= 1'b1;
      spi_sclk   <= 1'b0;
      spi_sdo    <= 1'b0;
      spi_sdo_oe <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      spi_csn  <= !w_sel_nxt;
      busy     <= (w_state_nxt != ST_IDLE);
      r_w_end  <= w_end_nxt;
      rd_valid <= w_end_nxt && r_rd;
      if (w_end_nxt && r_rd) r_ad_data <= r_rx;

      if (w_state_nxt != r_state) begin
        r_cnt <= '0;
      end else if ((r_state == ST_SETUP) || (r_state == ST_HOLD) ||
                   (r_state == ST_GAP)) begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end

      if (w_accept) begin
        r_tx    <= {read_req, ad_rw_addr[RW_BIT-1:0], w_ad_data};
        r_rd    <= read_req;
        spi_sdo <= read_req;
        r_bit   <= '0;
      end

      if (r_state == ST_SHIFT) begin
        if (w_rise) begin
          spi_sclk <= 1'b1;
          r_rx     <= {r_rx[DATA_W-2:0], spi_sdi};
        end
        if (w_fall) begin
          // Next bit is launched at the start of the low half.
          spi_sclk <= 1'b0;
          r_tx     <= r_tx << 1;
          spi_sdo  <= r_tx[FRAME_BITS-2];
          if (r_bit != c_bit_last) r_bit <= r_bit + 5'd1;
        end
      end else begin
        spi_sclk <= 1'b0;
      end

`ifdef AD9122_SPI_3WIRE_EN
      // Hand SDIO to the slave for the data byte of a read: released when
      // the first data bit's low half starts, reclaimed as HOLD begins.
      if ((r_state == ST_SHIFT) && (w_state_nxt == ST_HOLD)) begin
        spi_sdo_oe <= 1'b1;
      end else if ((r_state == ST_SHIFT) && w_fall && r_rd &&
                   (r_bit == 5'(INSTR_W - 1))) begin
        spi_sdo_oe <= 1'b0;
      end
`else
      spi_sdo_oe <= 1'b1;
`endif
    end
  end

endmodule
`default_nettype wire

// File: doc/ad9122_spi_master.md
# ad9122_spi_master

Serial-port master for the AD9122 DAC control interface. It sits directly downstream of the register-configuration sequencer. It accepts single-cycle write/read requests carrying an 8-bit instruction byte and an 8-bit data byte, and shifts them out as one 16-bit SPI frame. On completion it returns a one-cycle `r_w_end`, which the sequencer uses to advance to its next entry. Read frames capture the returned data byte for debug and readback.

## Interface
- `CLK_DIV`, 4: clk cycles per SCLK half-period; legal range 2..255. SCLK frequency is clk/(2·CLK_DIV).
- `clk` in 1: system clock; all logic is on the rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `ad_rw_addr` in 8: instruction byte. Bit 7 is replaced by the request type; bits 6:0 are the register address.
- `w_ad_data` in 8: write data byte; ignored on reads.
- `write_req` in 1: one-cycle write request.
- `read_req` in 1: one-cycle read request.
- `r_w_end` out 1: one-cycle pulse at the end of each accepted frame.
- `busy` out 1: high from the accepting edge until the cycle after `r_w_end`.
- `r_ad_data` out 8: last byte read back.
- `rd_valid` out 1: one-cycle pulse, coincident with `r_w_end`, on read frames only.
- `spi_csn` out 1: chip select, active low.
- `spi_sclk` out 1: serial clock; idles low.
- `spi_sdo` out 1: serial data out, MSB first.
- `spi_sdo_oe` out 1: output enable for `spi_sdo`.
- `spi_sdi` in 1: serial data in.

## Operation
- States:
  - IDLE → SETUP → SHIFT → HOLD → GAP → IDLE.
  - No other transitions exist.
  - Unused encodings return to IDLE.
- IDLE:
  - A request is accepted when `write_req | read_req` is high.
  - On acceptance, latch the shift register {`read_req`, `ad_rw_addr[6:0]`, `w_ad_data`}.
  - If both requests are high, the frame is a read.
  - Latch the read flag.
- SETUP:
  - `spi_csn` is low and `spi_sclk` is low.
  - `spi_sdo` = bit 15.
  - Lasts CLK_DIV cycles.
- SHIFT:
  - 16 bits, each a low half then a high half of CLK_DIV cycles.
  - `spi_sdo` changes only at the start of a low half.
  - `spi_sdi` is sampled into the read shift register on the clk edge that raises `spi_sclk`.
  - A 5-bit counter counts 0..15.
  - SHIFT ends after the 16th high half.
- HOLD:
  - `spi_sclk` is low and `spi_csn` is still low.
  - Lasts CLK_DIV cycles.
- GAP:
  - `spi_csn` is high.
  - Lasts CLK_DIV cycles.
  - `r_w_end` is high in the last GAP cycle.
  - On reads, `r_ad_data` ← the low 8 sampled bits and `rd_valid` is high in that same cycle.
- Requests arriving while `busy` is high are ignored: no queueing and no error.
- Because IDLE follows `r_w_end`, a request in the cycle after `r_w_end` is accepted. This is the sequencer's normal cadence.
- Reset values:
  - `spi_csn` = 1.
  - `spi_sclk` = 0, `spi_sdo` = 0, `spi_sdo_oe` = 1.
  - `r_w_end` = 0, `rd_valid` = 0, `busy` = 0.
  - `r_ad_data` = 0.
  - State = IDLE.
- Reset mid-frame:
  - The reset values apply immediately, including `spi_csn` high.
  - No `r_w_end` is produced.
  - The aborted frame is not retried.

## Timing
- All outputs are registered.
- Frame length from the accepting edge E0 to `r_w_end`:
  - `spi_csn` falls at E0.
  - `spi_csn` rises at E0 + 34·CLK_DIV.
  - `r_w_end` is high during the cycle after edge E0 + 35·CLK_DIV − 1.
  - With CLK_DIV = 4: 136 clocks of `spi_csn` low, and `r_w_end` at clock 140.
- Minimum `spi_csn`-high time between frames is CLK_DIV + 1 cycles.
- Setup and hold of `spi_sdo` around each SCLK rising edge is CLK_DIV clk cycles.

## Configuration
- Macro `AD9122_SPI_3WIRE_EN`.
- Defined:
  - For read frames, `spi_sdo_oe` drops to 0 at the start of the low half of bit 7 (the 9th bit) and stays low until HOLD begins.
  - `spi_sdo_oe` is 1 in all other states.
  - `spi_sdi` is connected at top level to the SDIO pad input, giving a 3-wire SDIO configuration.
- Undefined:
  - `spi_sdo_oe` is constant 1.
  - Read data comes from a separate SDO pin on `spi_sdi` (4-wire configuration; the sequencer's first writes set the SDIO bit accordingly).

## Structure
- Package `ad9122_pkg` holds:
  - the state enum;
  - FRAME_BITS = 16;
  - INSTR_W = 8 and DATA_W = 8;
  - the read/write bit position, 7.
- Sub-module `ad9122_sclk_gen`:
  - half-period divider, with the counter width sized for CLK_DIV;
  - emits a `rise_stb` and a `fall_stb` one-cycle strobe;
  - enabled only in SHIFT.
- The top FSM consumes these strobes.

## Test plan
- Write addr 0x00, data 0x20 → SDO bits 0x0020 MSB first.
  - `spi_csn` is low for 34·CLK_DIV cycles.
  - Exactly 16 SCLK rises.
  - `r_w_end` at E0 + 35·CLK_DIV; `rd_valid` is never high.
- Read addr 0x0D, slave returns 0xD9 → instruction 0x8D is shifted out, `r_ad_data` = 0xD9, and `rd_valid` is coincident with `r_w_end`.
- `write_req` and `read_req` high together (addr 0x18) → instruction 0x98 is sent as a read.
- `write_req` pulsed mid-frame → ignored: frame count unchanged and `busy` stays high.
- Back-to-back frames, with a request issued the cycle after `r_w_end` → accepted; `spi_csn` is high for CLK_DIV + 1 cycles.
- `rstn` asserted during bit 5 → `spi_csn` = 1 and `spi_sclk` = 0 immediately; no `r_w_end`; the next request runs a full frame.
- With `AD9122_SPI_3WIRE_EN` defined, on a read → `spi_sdo_oe` = 0 only during the data phase.
